// File: rtl/scg_pkg.sv
// Shared types and constants for the SDRAM opcode sequencer.
package scg_pkg;

   // Host opcodes as presented on the opcode bus.
   typedef enum logic [2:0] {
      OP_SREX = 3'd0,
      OP_NOP  = 3'd1,
      OP_SREF = 3'd2,
      OP_AREF = 3'd3,
      OP_RD   = 3'd4,
      OP_RDB  = 3'd5,
      OP_WR   = 3'd6,
      OP_WRB  = 3'd7
   } opcode_e;

   // Command-select codes understood by the command generator.
   localparam logic [3:0] SEL_NOP       = 4'd0;
   localparam logic [3:0] SEL_ACT       = 4'd1;
   localparam logic [3:0] SEL_RD        = 4'd2;
   localparam logic [3:0] SEL_RDB       = 4'd3;
   localparam logic [3:0] SEL_WR        = 4'd4;
   localparam logic [3:0] SEL_WRB       = 4'd5;
   localparam logic [3:0] SEL_AREF      = 4'd6;
   localparam logic [3:0] SEL_SREF      = 4'd7;
   localparam logic [3:0] SEL_SREX      = 4'd8;
   localparam logic [3:0] SEL_PRE       = 4'd9;
   localparam logic [3:0] SEL_LMR       = 4'd10;
   localparam logic [3:0] SEL_LMR_BURST = 4'd11;

   typedef enum logic [4:0] {
      StInitWait,
      StInitPre,
      StInitAref,
      StInitLmr,
      StReady,
      StAref,
      StRdAct,
      StRdData,
      StWrAct,
      StWrData,
      StBrstLmrIn,
      StBrstAct,
      StBrstData,
      StBrstLmrOut,
      StSrefPre,
      StSrefEnter,
      StSrefHold,
      StSrefExit
   } state_e;

   function automatic logic is_init(state_e s);
      return (s == StInitWait) || (s == StInitPre) || (s == StInitAref) || (s == StInitLmr);
   endfunction

endpackage

// File: rtl/scg_opcode_seq_if.sv
// Host opcode handshake plus command-select / done exchange with the command block.
interface scg_opcode_seq_if;
   logic [2:0] opcode;
   logic       op_valid;
   logic       op_ready;
   logic       done;
   logic [3:0] select;

   // master: host and command/timing block side
   modport master (output opcode, output op_valid, output done, input op_ready, input select);
   // slave: the sequencer
   modport slave (input opcode, input op_valid, input done, output op_ready, output select);
endinterface

// File: rtl/scg_refresh_timer.sv
// Periodic auto-refresh scheduler: interval counter, pending flag and sticky overrun.
module scg_refresh_timer #(
   parameter int unsigned REF_INTERVAL = 780
) (
   input  logic clk,
   input  logic rst,
   input  logic hold_i,
   input  logic clear_pending_i,
   input  logic restart_i,
   output logic expire_o,
   output logic ref_pending_o,
   output logic overrun_o
);

   localparam int unsigned RefW = $clog2(REF_INTERVAL);
   localparam logic [RefW-1:0] RefLast = RefW'(REF_INTERVAL - 1);

   logic [RefW-1:0] cnt_q, cnt_d;
   logic            pending_q, pending_d;
   logic            overrun_q, overrun_d;

   assign expire_o      = !hold_i && (cnt_q == RefLast);
   assign ref_pending_o = pending_q;
   assign overrun_o     = overrun_q;

   // Next-state: a clear on the expiry cycle wins over both set and overrun.
   always_comb begin
      cnt_d     = cnt_q + RefW'(1);
      pending_d = pending_q;
      overrun_d = overrun_q;
      if (hold_i || restart_i || expire_o) begin
         cnt_d = '0;
      end
      if (clear_pending_i) begin
         pending_d = 1'b0;
      end else if (expire_o) begin
         pending_d = 1'b1;
         if (pending_q) begin
            overrun_d = 1'b1;
         end
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q     <= '0;
         pending_q <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         pending_q <= pending_d;
         overrun_q <= overrun_d;
      end
   end

endmodule

// File: rtl/scg_opcode_seq.sv
// SDRAM opcode sequencer: init, single/burst access, self-refresh and scheduled refresh.
module scg_opcode_seq
   import scg_pkg::*;
#(
   parameter int unsigned INIT_CYCLES     = 100,
   parameter int unsigned INIT_AREF_COUNT = 2,
   parameter int unsigned BURST_BEATS     = 4,
   parameter int unsigned REF_INTERVAL    = 780
) (
   input  logic                   clk,
   input  logic                   rst,
   scg_opcode_seq_if.slave        bus,
   output logic                   idle,
   output logic                   init_busy,
   output logic                   illegal_op,
   output logic                   refresh_overrun
);

   localparam int unsigned WaitW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
   localparam int unsigned StepW = (INIT_AREF_COUNT > 1) ? $clog2(INIT_AREF_COUNT) : 1;
   localparam int unsigned BeatW = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;
   localparam logic [WaitW-1:0] WaitLast = WaitW'(INIT_CYCLES - 1);
   localparam logic [StepW-1:0] StepLast = StepW'(INIT_AREF_COUNT - 1);
   localparam logic [BeatW-1:0] BeatLast = BeatW'(BURST_BEATS - 1);

   state_e           state_q, state_d;
   logic [WaitW-1:0] wait_q, wait_d;
   logic [StepW-1:0] step_q, step_d;
   logic [BeatW-1:0] beat_q, beat_d;
   logic             dir_rd_q, dir_rd_d;
   logic             illegal_q, illegal_d;

   opcode_e op;
   logic    op_ready;
   logic    accept;
   logic    ref_hold, ref_expire, ref_pending, ref_overrun;
   logic    aref_entry, sref_entry;

   assign op = opcode_e'(bus.opcode);

   // A refresh that is pending or expiring this cycle takes READY away from the host.
   assign op_ready = ((state_q == StReady) && !(ref_pending || ref_expire)) ||
                     (state_q == StSrefHold);
   assign accept   = bus.op_valid && op_ready;

   assign ref_hold   = is_init(state_q) || (state_q == StSrefEnter) ||
                       (state_q == StSrefHold) || (state_q == StSrefExit);
   assign aref_entry = (state_d == StAref) && (state_q != StAref);
   assign sref_entry = (state_d == StSrefPre) && (state_q != StSrefPre);

   scg_refresh_timer #(
      .REF_INTERVAL (REF_INTERVAL)
   ) u_timer (
      .clk             (clk),
      .rst             (rst),
      .hold_i          (ref_hold),
      .clear_pending_i (aref_entry || sref_entry),
      .restart_i       (aref_entry),
      .expire_o        (ref_expire),
      .ref_pending_o   (ref_pending),
      .overrun_o       (ref_overrun)
   );

   // Next-state logic for the sequencer and its step/beat counters.
   always_comb begin
      state_d   = state_q;
      wait_d    = wait_q;
      step_d    = step_q;
      beat_d    = beat_q;
      dir_rd_d  = dir_rd_q;
      illegal_d = 1'b0;
      unique case (state_q)
         StInitWait: begin
            if (wait_q == WaitLast) begin
               wait_d  = '0;
               state_d = StInitPre;
            end else begin
               wait_d = wait_q + WaitW'(1);
            end
         end
         StInitPre:  if (bus.done) state_d = StInitAref;
         StInitAref: begin
            if (bus.done) begin
               if (step_q == StepLast) begin
                  step_d  = '0;
                  state_d = StInitLmr;
               end else begin
                  step_d = step_q + StepW'(1);
               end
            end
         end
         StInitLmr:  if (bus.done) state_d = StReady;
         StReady: begin
            if (ref_pending || ref_expire) begin
               state_d = StAref;
            end else if (accept) begin
               unique case (op)
                  OP_SREX: illegal_d = 1'b1;
                  OP_NOP:  state_d   = StReady;
                  OP_SREF: state_d   = StSrefPre;
                  OP_AREF: state_d   = StAref;
                  OP_RD:   state_d   = StRdAct;
                  OP_WR:   state_d   = StWrAct;
                  OP_RDB: begin
                     dir_rd_d = 1'b1;
                     state_d  = StBrstLmrIn;
                  end
                  OP_WRB: begin
                     dir_rd_d = 1'b0;
                     state_d  = StBrstLmrIn;
                  end
               endcase
            end
         end
         StAref:       if (bus.done) state_d = StReady;
         StRdAct:      if (bus.done) state_d = StRdData;
         StRdData:     if (bus.done) state_d = StReady;
         StWrAct:      if (bus.done) state_d = StWrData;
         StWrData:     if (bus.done) state_d = StReady;
         StBrstLmrIn:  if (bus.done) state_d = StBrstAct;
         StBrstAct:    if (bus.done) state_d = StBrstData;
         StBrstData: begin
            if (bus.done) begin
               if (beat_q == BeatLast) begin
                  beat_d  = '0;
                  state_d = StBrstLmrOut;
               end else begin
                  beat_d = beat_q + BeatW'(1);
               end
            end
         end
         StBrstLmrOut: if (bus.done) state_d = StReady;
         StSrefPre:    if (bus.done) state_d = StSrefEnter;
         StSrefEnter:  if (bus.done) state_d = StSrefHold;
         StSrefHold: begin
            if (accept) begin
               if (op == OP_SREX) state_d = StSrefExit;
               else               illegal_d = 1'b1;
            end
         end
         StSrefExit:   if (bus.done) state_d = StReady;
         default:      state_d = StInitWait;
      endcase
   end

   // Sequencer registers; reset aborts any in-flight sequence.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StInitWait;
         wait_q    <= '0;
         step_q    <= '0;
         beat_q    <= '0;
         dir_rd_q  <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         step_q    <= step_d;
         beat_q    <= beat_d;
         dir_rd_q  <= dir_rd_d;
         illegal_q <= illegal_d;
      end
   end

   // Command select decoded directly from the current state.
   always_comb begin
      bus.select = SEL_NOP;
      unique case (state_q)
         StInitPre, StSrefPre:               bus.select = SEL_PRE;
         StInitAref, StAref:                 bus.select = SEL_AREF;
         StInitLmr, StBrstLmrOut:            bus.select = SEL_LMR;
         StRdAct, StWrAct, StBrstAct:        bus.select = SEL_ACT;
         StRdData:                           bus.select = SEL_RD;
         StWrData:                           bus.select = SEL_WR;
         StBrstLmrIn:                        bus.select = SEL_LMR_BURST;
         StBrstData:                         bus.select = dir_rd_q ? SEL_RDB : SEL_WRB;
         StSrefEnter:                        bus.select = SEL_SREF;
         StSrefExit:                         bus.select = SEL_SREX;
         default:                            bus.select = SEL_NOP;
      endcase
   end

   assign bus.op_ready     = op_ready;
   assign idle             = (state_q == StReady);
   assign init_busy        = is_init(state_q);
   assign illegal_op       = illegal_q;
   assign refresh_overrun  = ref_overrun;

endmodule
